// File: rtl/btn_debouncer_multi.sv
// N-channel push-button conditioner: synchroniser, stability-count debounce,
// clean level plus one-cycle press/release pulses and optional auto-repeat.
module btn_debouncer_multi #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_ni,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] pressed_o,
  output logic [N_BTN-1:0] released_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic             any_pressed_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic INACTIVE = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] r_sync [N_BTN];
  logic [CNT_W-1:0]       r_cnt  [N_BTN];
  logic [N_BTN-1:0]       r_level;
  logic [N_BTN-1:0]       r_pressed;
  logic [N_BTN-1:0]       r_released;
  logic [N_BTN-1:0]       w_p;
  logic [N_BTN-1:0]       w_accept;

  // Synchronisers idle at the released raw level so reset exit never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_sync[i] <= {SYNC_STAGES{INACTIVE}};
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], btn_ni[i]};
      end
    end
  end

  always_comb begin
    w_p      = '0;
    w_accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_p[i]      = r_sync[i][SYNC_STAGES-1] ^ ACTIVE_LOW;
      w_accept[i] = (w_p[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level    <= '0;
      r_pressed  <= '0;
      r_released <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_pressed  <= w_accept & w_p;
      r_released <= w_accept & ~w_p;
      for (int i = 0; i < N_BTN; i++) begin
        if (w_p[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= w_p[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;
      localparam logic [HC_W-1:0] HOLD_END = HC_W'(HOLD_CYCLES - 1);
      localparam logic [HC_W-1:0] REP_END  = HC_W'(REPEAT_CYCLES - 1);

      logic [HC_W-1:0]  r_hcnt [N_BTN];
      logic [N_BTN-1:0] r_phase;
      logic [N_BTN-1:0] r_repeat;

      // r_phase=0: waiting out the initial hold; r_phase=1: periodic repeat.
      // hcnt restarts at every pulse, so it never exceeds the longer period.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_phase  <= '0;
          r_repeat <= '0;
          for (int i = 0; i < N_BTN; i++) begin
            r_hcnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < N_BTN; i++) begin
            if (w_accept[i] || !r_level[i]) begin
              r_hcnt[i]   <= '0;
              r_phase[i]  <= 1'b0;
              r_repeat[i] <= 1'b0;
            end else if (!r_phase[i] && r_hcnt[i] == HOLD_END) begin
              r_hcnt[i]   <= '0;
              r_phase[i]  <= 1'b1;
              r_repeat[i] <= 1'b1;
            end else if (r_phase[i] && r_hcnt[i] == REP_END) begin
              r_hcnt[i]   <= '0;
              r_repeat[i] <= 1'b1;
            end else begin
              r_hcnt[i]   <= r_hcnt[i] + HC_W'(1);
              r_repeat[i] <= 1'b0;
            end
          end
        end
      end

      assign repeat_o = r_repeat;
    end else begin : g_no_rep
      assign repeat_o = '0;
    end
  endgenerate

  assign level_o       = r_level;
  assign pressed_o     = r_pressed;
  assign released_o    = r_released;
  assign any_pressed_o = |r_level;

endmodule

// File: tb/tb_btn_debouncer_multi.sv
// Bench for btn_debouncer_multi: three differently configured instances driven
// by directed vectors, checked every cycle against a window-based model.
module tb_btn_debouncer_multi;

  localparam int NB = 4;
  localparam int NI = 3;
  localparam int S  = 2;
  localparam int H  = 10;
  localparam int R  = 3;
  localparam int P_D [NI] = '{4, 4, 2};
  localparam bit P_AL[NI] = '{1'b1, 1'b0, 1'b1};
  localparam bit P_RE[NI] = '{1'b0, 1'b0, 1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0] btn [NI];
  logic [NB-1:0] lvl [NI];
  logic [NB-1:0] prs [NI];
  logic [NB-1:0] rel [NI];
  logic [NB-1:0] rpt [NI];
  logic          anyp[NI];

  btn_debouncer_multi #(.N_BTN(NB), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_ni(btn[0]), .level_o(lvl[0]), .pressed_o(prs[0]),
    .released_o(rel[0]), .repeat_o(rpt[0]), .any_pressed_o(anyp[0]));

  btn_debouncer_multi #(.N_BTN(NB), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_ni(btn[1]), .level_o(lvl[1]), .pressed_o(prs[1]),
    .released_o(rel[1]), .repeat_o(rpt[1]), .any_pressed_o(anyp[1]));

  btn_debouncer_multi #(.N_BTN(NB), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(2),
    .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_c (
    .clk(clk), .rst_n(rst_n), .btn_ni(btn[2]), .level_o(lvl[2]), .pressed_o(prs[2]),
    .released_o(rel[2]), .repeat_o(rpt[2]), .any_pressed_o(anyp[2]));

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pcnt [NI][NB];
  int rcnt [NI][NB];
  int press_cyc = 0;
  int rep_off[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A change is accepted when the last D synchronised samples (since reset) all
  // disagree with the current level; the sample seen at an edge is the raw value
  // captured S edges earlier. Repeat timing is pure arithmetic on hold age.
  logic [7:0]    m_rh  [NI][NB];
  logic [7:0]    m_hist[NI][NB];
  int            m_nv  [NI][NB];
  int            m_age [NI][NB];
  logic [NB-1:0] m_lvl [NI];
  logic [NB-1:0] m_prs [NI];
  logic [NB-1:0] m_rel [NI];
  logic [NB-1:0] m_rpt [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NB; c++) begin
        logic p;
        logic flip;
        if (!rst_n) begin
          m_rh[i][c]   = {8{P_AL[i]}};
          m_hist[i][c] = '0;
          m_nv[i][c]   = 0;
          m_age[i][c]  = 0;
          m_lvl[i][c]  = 1'b0;
          m_prs[i][c]  = 1'b0;
          m_rel[i][c]  = 1'b0;
          m_rpt[i][c]  = 1'b0;
        end else begin
          p = m_rh[i][c][S-1] ^ P_AL[i];
          m_rh[i][c]   = {m_rh[i][c][6:0], btn[i][c]};
          m_hist[i][c] = {m_hist[i][c][6:0], p};
          if (m_nv[i][c] < 8) m_nv[i][c]++;
          flip = (m_nv[i][c] >= P_D[i]);
          for (int k = 0; k < P_D[i]; k++) begin
            if (m_hist[i][c][k] == m_lvl[i][c]) flip = 1'b0;
          end
          m_prs[i][c] = 1'b0;
          m_rel[i][c] = 1'b0;
          m_rpt[i][c] = 1'b0;
          if (flip) begin
            m_lvl[i][c] = ~m_lvl[i][c];
            m_prs[i][c] = m_lvl[i][c];
            m_rel[i][c] = ~m_lvl[i][c];
            m_age[i][c] = 0;
          end else if (m_lvl[i][c] && P_RE[i]) begin
            m_age[i][c]++;
            m_rpt[i][c] = (m_age[i][c] == H) ||
                          (m_age[i][c] > H && ((m_age[i][c] - H) % R) == 0);
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("level[%0d]", i),    32'(lvl[i]),  32'(m_lvl[i]));
      chk($sformatf("pressed[%0d]", i),  32'(prs[i]),  32'(m_prs[i]));
      chk($sformatf("released[%0d]", i), 32'(rel[i]),  32'(m_rel[i]));
      chk($sformatf("repeat[%0d]", i),   32'(rpt[i]),  32'(m_rpt[i]));
      chk($sformatf("any[%0d]", i),      32'(anyp[i]), 32'(|m_lvl[i]));
      for (int c = 0; c < NB; c++) begin
        if (prs[i][c]) pcnt[i][c]++;
        if (rel[i][c]) rcnt[i][c]++;
      end
    end
    if (prs[2][0]) press_cyc = cyc;
    if (rpt[2][0]) rep_off.push_back(cyc - press_cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int tot_before;
  int tot_after;

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NB; c++) begin
        pcnt[i][c] = 0;
        rcnt[i][c] = 0;
      end
    end
    btn[0] = 4'hF;
    btn[1] = 4'h0;
    btn[2] = 4'hF;
    rst_n  = 1'b0;
    wait_neg(3);
    chk("rst_level_a", 32'(lvl[0]), 32'h0);
    chk("rst_pressed_a", 32'(prs[0]), 32'h0);
    chk("rst_released_b", 32'(rel[1]), 32'h0);
    chk("rst_repeat_c", 32'(rpt[2]), 32'h0);
    chk("rst_any_c", 32'(anyp[2]), 32'h0);
    rst_n = 1'b1;
    wait_neg(3);

    // clean press / release on a[0]: accepted at edge S+D = 6
    btn[0][0] = 1'b0;
    at_edge(5);
    chk("t1_level_e5", 32'(lvl[0][0]), 32'h0);
    at_edge(1);
    chk("t1_pressed_e6", 32'(prs[0]), 32'h1);
    chk("t1_level_e6", 32'(lvl[0][0]), 32'h1);
    at_edge(1);
    chk("t1_pressed_e7", 32'(prs[0]), 32'h0);
    wait_neg(3);
    btn[0][0] = 1'b1;
    at_edge(5);
    chk("t1_released_e5", 32'(rel[0]), 32'h0);
    at_edge(1);
    chk("t1_released_e6", 32'(rel[0]), 32'h1);
    chk("t1_level_rel", 32'(lvl[0][0]), 32'h0);
    wait_neg(4);

    // bounce on a[1]: 3 low / 1 high never reaches 4 stable samples
    for (int k = 0; k < 5; k++) begin
      btn[0][1] = 1'b0;
      wait_neg(3);
      btn[0][1] = 1'b1;
      wait_neg(1);
    end
    wait_neg(8);
    chk("t2_bounce_presses", 32'(pcnt[0][1]), 32'h0);
    chk("t2_bounce_level", 32'(lvl[0][1]), 32'h0);
    btn[0][1] = 1'b0;
    wait_neg(10);
    chk("t2_held_presses", 32'(pcnt[0][1]), 32'h1);
    btn[0][1] = 1'b1;
    wait_neg(10);
    chk("t2_releases", 32'(rcnt[0][1]), 32'h1);

    // active-high polarity on b[2]
    btn[1][2] = 1'b1;
    wait_neg(10);
    chk("t3_level_b2", 32'(lvl[1][2]), 32'h1);
    chk("t3_any_b", 32'(anyp[1]), 32'h1);
    wait_neg(10);
    chk("t3_presses_b2", 32'(pcnt[1][2]), 32'h1);
    btn[1][2] = 1'b0;
    wait_neg(10);

    // auto-repeat on c[0]: held 30 cycles, repeats at +10,+13,...,+28
    rep_off.delete();
    btn[2][0] = 1'b0;
    wait_neg(30);
    btn[2][0] = 1'b1;
    wait_neg(20);
    chk("t4_repeat_count", 32'(rep_off.size()), 32'd7);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_repeat_off%0d", k),
          (k < rep_off.size()) ? 32'(rep_off[k]) : 32'hFFFF_FFFF, 32'(10 + 3 * k));
    end
    chk("t4_presses_c0", 32'(pcnt[2][0]), 32'h1);
    chk("t4_releases_c0", 32'(rcnt[2][0]), 32'h1);

    // simultaneous a[0] and a[3]
    btn[0][0] = 1'b0;
    btn[0][3] = 1'b0;
    at_edge(6);
    chk("t5_pressed_1001", 32'(prs[0]), 32'h9);
    chk("t5_level_mid", 32'({lvl[0][2], lvl[0][1]}), 32'h0);
    wait_neg(1);
    btn[0] = 4'hF;
    wait_neg(10);

    // reset mid-debounce with a[2] and c[1] already held
    btn[0][2] = 1'b0;
    btn[2][1] = 1'b0;
    wait_neg(8);
    btn[0][0] = 1'b0;
    at_edge(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level_a", 32'(lvl[0]), 32'h0);
    chk("t6_rst_any_a", 32'(anyp[0]), 32'h0);
    chk("t6_rst_level_c", 32'(lvl[2]), 32'h0);
    wait_neg(2);
    rst_n = 1'b1;
    at_edge(5);
    chk("t6_pressed_e5", 32'(prs[0]), 32'h0);
    at_edge(1);
    chk("t6_pressed_e6", 32'(prs[0]), 32'h5);
    wait_neg(1);
    btn[0] = 4'hF;
    btn[2] = 4'hF;
    wait_neg(15);

    // reset with b idle low must produce no pulses
    tot_before = 0;
    for (int c = 0; c < NB; c++) tot_before += pcnt[1][c] + rcnt[1][c];
    rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(20);
    tot_after = 0;
    for (int c = 0; c < NB; c++) tot_after += pcnt[1][c] + rcnt[1][c];
    chk("t7_idle_pulses_b", 32'(tot_after - tot_before), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debouncer_multi.md
Name: btn_debouncer_multi

Overview:
Parametrised N-channel successor to the single-button edge detector. Per channel it synchronises the raw button input and debounces it with a stability counter. It then emits a clean level plus single-cycle press, release and auto-repeat pulses. It sits between board push-buttons and the control FSMs, which consume only the pulses and levels.

Parameters:
N_BTN, 4, number of independent button channels
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised samples required to accept a change (>=1)
ACTIVE_LOW, 1, 1: raw input low = pressed; 0: raw input high = pressed
REPEAT_EN, 0, 1 enables auto-repeat pulses while a button is held
HOLD_CYCLES, 50000000, cycles from accepted press to first repeat_o pulse (>=1)
REPEAT_CYCLES, 10000000, cycles between subsequent repeat_o pulses (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
btn_ni  input  N_BTN  raw asynchronous button inputs, polarity per ACTIVE_LOW
level_o  output  N_BTN  debounced level, 1 = pressed
pressed_o  output  N_BTN  one-cycle pulse on accepted press
released_o  output  N_BTN  one-cycle pulse on accepted release
repeat_o  output  N_BTN  one-cycle auto-repeat pulse (always 0 if REPEAT_EN=0)
any_pressed_o  output  1  OR of level_o (combinational from registers)

Behaviour:
- Reset: clk and rst_n (asynchronous, active-low). All synchroniser flops reset to the inactive raw level (1 if ACTIVE_LOW, else 0).
- Reset values: level_o=0, pressed_o=0, released_o=0, repeat_o=0, all counters=0.
- Reset mid-operation clears everything immediately. No pulse is emitted on reset exit, even if a button is held. A held button is then re-accepted after the normal latency.
- Synchroniser: sample p = synchronised raw input XOR ACTIVE_LOW, so p=1 means pressed.
- Debounce counter cnt, per channel, width clog2(DEBOUNCE_CYCLES) (min 1):
  - p == level_o: cnt <= 0.
  - p != level_o and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - p != level_o and cnt == DEBOUNCE_CYCLES-1: level_o <= p, cnt <= 0.
- Glitch rejection: any glitch shorter than DEBOUNCE_CYCLES synchronised samples resets cnt and is fully rejected.
- Latency: a raw change stable from sampling edge 1 updates level_o at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- pressed_o / released_o: registered and asserted for exactly the one cycle in which level_o first shows 1 / 0. They never assert together.
- Auto-repeat (REPEAT_EN=1), hold counter hcnt per channel:
  - Cleared at the accepted-press edge.
  - Increments while level_o=1.
  - First repeat_o occurs HOLD_CYCLES edges after the edge that raised level_o. Subsequent pulses occur every REPEAT_CYCLES edges.
  - Release clears hcnt. No repeat_o in or after the released_o cycle.
  - repeat_o never coincides with pressed_o.
  - hcnt saturates safely (wraps only within the repeat period, never overflows).
- Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
- REPEAT_EN=0: repeat logic is not instantiated; repeat_o is tied to 0.

Test Plan:
- Clean press, defaults except DEBOUNCE_CYCLES=4, ACTIVE_LOW=1: btn_ni[0] 1->0 held -> level_o[0]=1 and pressed_o[0] one-cycle pulse at edge 6. Release the same way -> released_o[0] pulse at edge 6 after release.
- Bounce rejection, DEBOUNCE_CYCLES=4: btn_ni[1] low for 3 cycles, high 1 cycle, repeated 5 times -> no pulses, level_o=0. Then low for 10 cycles -> exactly one pressed_o[1].
- Polarity, ACTIVE_LOW=0: btn_ni[2] 0->1 held 20 cycles -> pressed_o[2] pulse, any_pressed_o=1. After reset with inputs idle at 0 -> no pulses.
- Auto-repeat, REPEAT_EN=1, HOLD_CYCLES=10, REPEAT_CYCLES=3, DEBOUNCE_CYCLES=2: hold btn 30 cycles -> pressed_o, then repeat_o at +10, +13, +16, ... after the press edge. Release -> released_o and no further repeat_o.
- Simultaneous channels: press btn 0 and 3 on the same edge -> pressed_o=4'b1001 in a single cycle; level_o[1], level_o[2] stay 0.
- Reset mid-debounce: assert rst_n low while cnt=2 with the button held -> outputs 0 immediately. Release reset with the button still held -> pressed_o after the full SYNC_STAGES+DEBOUNCE_CYCLES latency.
